// File: rtl/opl3_reg_write_queue_if.sv
// Host-side and register-file-side signals of the OPL3 register write queue.
// The slave modport is the queue itself; the master modport is whoever drives the host port.
interface opl3_reg_write_queue_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                  host_wr;
  logic [1:0]            host_a;
  logic [DATA_WIDTH-1:0] host_din;
  logic                  drain_en;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dia;
  logic [LVL_W-1:0]      level;
  logic                  busy;
  logic                  overflow;

  modport master (
    output host_wr, host_a, host_din, drain_en,
    input  wea, addra, dia, level, busy, overflow
  );

  modport slave (
    input  host_wr, host_a, host_din, drain_en,
    output wea, addra, dia, level, busy, overflow
  );
endinterface

// File: rtl/opl3_reg_write_queue.sv
// Decodes OPL3 address/data port writes, queues complete register writes in a FIFO,
// and replays them as single-cycle register-file writes whenever drain_en allows.
module opl3_reg_write_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  opl3_reg_write_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [ENT_W-1:0]      mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] addr_latch_q, addr_latch_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  wea_q, wea_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [DATA_WIDTH-1:0] dia_q, dia_d;

  logic addr_load;
  logic push;
  logic pop;
  logic push_ok;
  logic empty;
  logic full;

  assign addr_load = bus.host_wr & ~bus.host_a[0];
  assign push      = bus.host_wr &  bus.host_a[0];
  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_FULL);
  assign pop       = bus.drain_en & ~empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign push_ok   = push & (~full | pop);

  always_comb begin
    addr_latch_d = addr_latch_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    wea_d        = 1'b0;
    addra_d      = addra_q;
    dia_d        = dia_q;

    if (addr_load) begin
      addr_latch_d = ADDR_WIDTH'({bus.host_a[1], bus.host_din});
    end

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d           = rd_ptr_q + PTR_W'(1);
      wea_d              = 1'b1;
      {addra_d, dia_d}   = mem_q[rd_ptr_q];
    end

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_latch_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      wea_q        <= 1'b0;
      addra_q      <= '0;
      dia_q        <= '0;
    end else begin
      addr_latch_q <= addr_latch_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      wea_q        <= wea_d;
      addra_q      <= addra_d;
      dia_q        <= dia_d;
    end
  end

  // Storage needs no reset: level and pointers decide which entries are valid.
  // The head is read combinationally above, so a full-FIFO push/pop overwrites it safely.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {addr_latch_q, bus.host_din};
    end
  end

  assign bus.wea      = wea_q;
  assign bus.addra    = addra_q;
  assign bus.dia      = dia_q;
  assign bus.level    = level_q;
  assign bus.busy     = ~empty;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_opl3_reg_write_queue.sv
// Scoreboard bench for the OPL3 register write queue: a reference model queues expected
// writes as the host drives them, and the monitor pops and compares on every wea.
module tb_opl3_reg_write_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int AW    = 9;

  logic clk;
  logic reset;

  opl3_reg_write_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  opl3_reg_write_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, advanced on the same edges as the DUT.
  logic [AW+DW-1:0] sbq [$];
  logic [AW-1:0]    m_latch;
  int               m_level;
  logic             m_ovf;
  logic             exp_wea;
  logic [AW-1:0]    exp_addr;
  logic [DW-1:0]    exp_dia;
  logic             m_pop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sbq.delete();
      m_latch  = '0;
      m_level  = 0;
      m_ovf    = 1'b0;
      exp_wea  = 1'b0;
      exp_addr = '0;
      exp_dia  = '0;
    end else begin
      m_pop   = bus.drain_en && (sbq.size() != 0);
      exp_wea = m_pop;
      if (m_pop) {exp_addr, exp_dia} = sbq.pop_front();
      if (bus.host_wr && bus.host_a[0]) begin
        if (sbq.size() < DEPTH || m_pop) sbq.push_back({m_latch, bus.host_din});
        else m_ovf = 1'b1;
      end
      if (bus.host_wr && !bus.host_a[0]) m_latch = {bus.host_a[1], bus.host_din};
      m_level = sbq.size();
    end
  end

  logic [AW+DW-1:0] obs [$];
  int               wea_cnt;

  always @(negedge clk) begin
    if (!reset) begin
      chk("wea", 32'(bus.wea), 32'(exp_wea));
      if (exp_wea) begin
        chk("addra", 32'(bus.addra), 32'(exp_addr));
        chk("dia", 32'(bus.dia), 32'(exp_dia));
      end
      chk("level", 32'(bus.level), 32'(m_level));
      chk("busy", 32'(bus.busy), 32'(m_level != 0));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      if (bus.wea) begin
        obs.push_back({bus.addra, bus.dia});
        wea_cnt++;
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic addr_wr(input logic bank, input logic [7:0] idx);
    bus.host_wr  = 1'b1;
    bus.host_a   = {bank, 1'b0};
    bus.host_din = idx;
    tick();
    bus.host_wr  = 1'b0;
  endtask

  task automatic data_wr(input logic [7:0] d, input logic a1 = 1'b0);
    bus.host_wr  = 1'b1;
    bus.host_a   = {a1, 1'b1};
    bus.host_din = d;
    tick();
    bus.host_wr  = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input logic [AW-1:0] addr,
                         input logic [7:0] first, input int n);
    chk({tag, "_count"}, 32'(obs.size()), 32'(n));
    for (int i = 0; i < n && i < obs.size(); i++) begin
      chk({tag, "_addra"}, 32'(obs[i][AW+DW-1:DW]), 32'(addr));
      chk({tag, "_dia"}, 32'(obs[i][DW-1:0]), 32'(first + 8'(i)));
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    wea_cnt      = 0;
    reset        = 1'b1;
    bus.host_wr  = 1'b0;
    bus.host_a   = 2'b00;
    bus.host_din = '0;
    bus.drain_en = 1'b0;
    #2;
    chk("rst_wea", 32'(bus.wea), 32'h0);
    chk("rst_level", 32'(bus.level), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    tick(2);
    reset = 1'b0;
    tick();

    // Basic write: bank 1 address 0xB0, data 0x31, drain enabled.
    bus.drain_en = 1'b1;
    addr_wr(1'b1, 8'hB0);
    wea_cnt = 0;
    obs.delete();
    data_wr(8'h31);
    chk("basic_level1", 32'(bus.level), 32'd1);
    chk("basic_wea_n1", 32'(bus.wea), 32'd0);
    tick();
    chk("basic_wea_n2", 32'(bus.wea), 32'd1);
    chk("basic_addra", 32'(bus.addra), 32'h1B0);
    chk("basic_dia", 32'(bus.dia), 32'h31);
    chk("basic_level0", 32'(bus.level), 32'd0);
    tick(4);
    chk("basic_pulses", 32'(wea_cnt), 32'd1);

    // Latch reuse: A1 set on data writes must not change the bank.
    bus.drain_en = 1'b0;
    addr_wr(1'b0, 8'h20);
    data_wr(8'h01, 1'b1);
    data_wr(8'h02, 1'b1);
    data_wr(8'h03, 1'b1);
    chk("reuse_level", 32'(bus.level), 32'd3);
    chk("reuse_busy", 32'(bus.busy), 32'd1);
    obs.delete();
    bus.drain_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reuse_b2b_wea", 32'(bus.wea), 32'd1);
    end
    tick();
    chk("reuse_wea_end", 32'(bus.wea), 32'd0);
    chk_seq("reuse", 9'h020, 8'h01, 3);

    // Overflow: five writes into a four-entry FIFO.
    bus.drain_en = 1'b0;
    for (int i = 0; i < 5; i++) data_wr(8'h10 + 8'(i));
    chk("ovf_level", 32'(bus.level), 32'd4);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    obs.delete();
    bus.drain_en = 1'b1;
    tick(7);
    chk_seq("ovf_drain", 9'h020, 8'h10, 4);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Asynchronous reset mid-cycle with state present.
    bus.drain_en = 1'b0;
    data_wr(8'h55);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_wea", 32'(bus.wea), 32'h0);
    chk("arst_addra", 32'(bus.addra), 32'h0);
    chk("arst_dia", 32'(bus.dia), 32'h0);
    chk("arst_level", 32'(bus.level), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_overflow", 32'(bus.overflow), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Full FIFO with simultaneous push and pop; latch is 0 after reset.
    for (int i = 0; i < 4; i++) data_wr(8'h10 + 8'(i));
    chk("full_level", 32'(bus.level), 32'd4);
    obs.delete();
    bus.drain_en = 1'b1;
    data_wr(8'h14);
    chk("full_pp_level", 32'(bus.level), 32'd4);
    chk("full_pp_ovf", 32'(bus.overflow), 32'd0);
    tick(7);
    chk_seq("full_pp_drain", 9'h000, 8'h10, 5);
    chk("full_pp_ovf_end", 32'(bus.overflow), 32'd0);

    // Reset mid-drain, then a data write with no fresh address write.
    bus.drain_en = 1'b0;
    addr_wr(1'b1, 8'h40);
    for (int i = 0; i < 3; i++) data_wr(8'hA0 + 8'(i));
    bus.drain_en = 1'b1;
    tick();
    chk("mdr_first_wea", 32'(bus.wea), 32'd1);
    chk("mdr_first_dia", 32'(bus.dia), 32'hA0);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    wea_cnt = 0;
    tick(5);
    chk("mdr_no_wea", 32'(wea_cnt), 32'd0);
    chk("mdr_level", 32'(bus.level), 32'd0);
    obs.delete();
    data_wr(8'h77);
    tick(3);
    chk_seq("post_rst", 9'h000, 8'h77, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
